// File: rtl/iq_src_pkg.sv
// Shared types and constants for the IQ test-pattern source.
// Pattern modes, LFSR tap masks per lane width, default seed.
package iq_src_pkg;

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  // Fibonacci taps, shift-left form: feedback = ^(x & taps) into bit 0
  localparam logic [31:0] TAPS_DW8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_DW16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_DW24 = 32'h00E1_0000;
  localparam logic [31:0] TAPS_DW32 = 32'h8020_0003;

  localparam logic [31:0] DEF_SEED = 32'h0000_ACE1;

  function automatic logic [31:0] lfsr_taps(input int dw);
    logic [31:0] t;
    t = TAPS_DW16;
    if (dw == 8)  t = TAPS_DW8;
    if (dw == 24) t = TAPS_DW24;
    if (dw == 32) t = TAPS_DW32;
    return t;
  endfunction

  // Per-lane seed, truncated to the lane width; all-zero would lock up
  function automatic logic [31:0] lane_seed(
    input logic [31:0] seed,
    input int          lane,
    input int          dw
  );
    logic [31:0] s;
    s = seed ^ 32'(lane + 1);
    if (dw < 32) s = s & ((32'd1 << dw) - 32'd1);
    if (s == 32'd0) s = 32'd1;
    return s;
  endfunction

endpackage

// File: rtl/iq_src_lane.sv
// One sample lane: holds the lane value and computes its successor.
// Reload (initial value for i_mode) takes priority over advance.
module iq_src_lane
  import iq_src_pkg::*;
#(
  parameter int          DW   = 16,
  parameter bit          UP   = 1'b1,
  parameter logic [31:0] SEED = DEF_SEED,
  parameter int          LANE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_adv,
  input  logic          i_reload,
  input  logic [1:0]    i_mode,
  input  logic [DW-1:0] i_step,
  output logic [DW-1:0] o_val
);

  localparam logic [DW-1:0] TAPS  = DW'(lfsr_taps(DW));
  localparam logic [DW-1:0] SEEDL = DW'(lane_seed(SEED, LANE, DW));
  localparam logic [DW-1:0] WALK0 = DW'(32'd1 << (LANE % DW));

  mode_e         w_mode;
  logic [DW-1:0] r_x;
  logic [DW-1:0] w_init;
  logic [DW-1:0] w_next;

  assign w_mode = mode_e'(i_mode);
  assign o_val  = r_x;

  // Initial lane value for the selected mode
  always_comb begin
    w_init = '0;
    unique case (1'b1)
      (w_mode == MODE_CNT):   w_init = '0;
      (w_mode == MODE_LFSR):  w_init = SEEDL;
      (w_mode == MODE_CONST): w_init = i_step;
      (w_mode == MODE_WALK):  w_init = WALK0;
    endcase
  end

  // Successor value for the selected mode
  always_comb begin
    w_next = r_x;
    unique case (1'b1)
      (w_mode == MODE_CNT):
        w_next = UP ? r_x + i_step : r_x - i_step;
      (w_mode == MODE_LFSR):
        w_next = {r_x[DW-2:0], ^(r_x & TAPS)};
      (w_mode == MODE_CONST):
        w_next = i_step;
      (w_mode == MODE_WALK):
        w_next = {r_x[DW-2:0], r_x[DW-1]};
    endcase
  end

  // Lane state; reset value is the counter start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
    end else if (i_reload) begin
      r_x <= w_init;
    end else if (i_adv) begin
      r_x <= w_next;
    end
  end

endmodule

// File: rtl/iq_pattern_src.sv
// Multi-lane test-sample source with valid/ready, frame markers.
// Optional error injection on lane 0 LSB: PATTERN_ERRINJ_EN.
module iq_pattern_src
  import iq_src_pkg::*;
#(
  parameter int          CH        = 2,
  parameter int          DW        = 16,
  parameter int          FRAME_LEN = 1024,
  parameter logic [CH-1:0] DIR_MASK = 'b10,
  parameter logic [31:0] SEED      = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    step,
  output logic [CH*DW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sync,
  output logic             out_last,
  output logic [15:0]      frame_cnt,
  input  logic             inj_err
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  logic             r_valid;
  logic [15:0]      r_idx;
  logic [15:0]      r_frame;
  mode_e            r_mode;
  mode_e            w_mode_in;
  mode_e            w_mode_nxt;
  logic             w_xfer;
  logic             w_wrap;
  logic             w_mode_ld;
  logic             w_reload;
  logic [CH*DW-1:0] w_lane;

  assign w_xfer     = r_valid & out_ready;
  assign w_wrap     = (r_idx == LAST_IDX);
  assign w_mode_in  = mode_e'(mode);
  assign w_mode_ld  = clear | (w_xfer & w_wrap) | ~r_valid;
  assign w_mode_nxt = w_mode_ld ? w_mode_in : r_mode;
  assign w_reload   = clear |
                      (w_mode_ld & (w_mode_in != r_mode));

  genvar k;
  generate
    for (k = 0; k < CH; k++) begin : g_lane
      iq_src_lane #(
        .DW   (DW),
        .UP   (DIR_MASK[k]),
        .SEED (SEED),
        .LANE (k)
      ) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_adv    (w_xfer),
        .i_reload (w_reload),
        .i_mode   (w_mode_nxt),
        .i_step   (step),
        .o_val    (w_lane[k*DW +: DW])
      );
    end
  endgenerate

  // Valid: rises after en, holds an untransferred sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_valid & ~w_xfer) | en;
    end
  end

  // Sample index, completed-frame count and active mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_frame <= '0;
      r_mode  <= MODE_CNT;
    end else begin
      r_mode <= w_mode_nxt;
      if (clear) begin
        r_idx   <= '0;
        r_frame <= '0;
      end else if (w_xfer) begin
        r_idx <= w_wrap ? 16'd0 : r_idx + 16'd1;
        if (w_wrap) r_frame <= r_frame + 16'd1;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_sync  = r_valid & (r_idx == 16'd0);
  assign out_last  = r_valid & w_wrap;
  assign frame_cnt = r_frame;

`ifdef PATTERN_ERRINJ_EN
  logic r_arm;
  logic r_flip;
  logic w_load;

  // A new sample is presented after a transfer or while idle
  assign w_load = ~r_valid | w_xfer;

  // Arm on request; apply to the next presented sample only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm  <= 1'b0;
      r_flip <= 1'b0;
    end else if (w_load) begin
      r_flip <= (r_flip & ~w_xfer) | r_arm | inj_err;
      r_arm  <= 1'b0;
    end else begin
      r_arm <= r_arm | (inj_err & ~r_flip);
    end
  end

  assign out_data = w_lane ^ {{(CH*DW-1){1'b0}}, r_flip};
`else
  logic w_unused_inj;
  assign w_unused_inj = inj_err;
  assign out_data     = w_lane;
`endif

endmodule

// File: tb/tb_iq_pattern_src.sv
// Bench for iq_pattern_src (CH=2, DW=16, FRAME_LEN=8).
// Vector table, model-fed scoreboard and directed corner sequences.
module tb_iq_pattern_src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clear;
  logic [1:0]  mode;
  logic [15:0] step;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sync;
  logic        out_last;
  logic [15:0] frame_cnt;
  logic        inj_err;

`ifdef PATTERN_ERRINJ_EN
  localparam logic [15:0] INJ = 16'h0001;
`else
  localparam logic [15:0] INJ = 16'h0000;
`endif

  iq_pattern_src #(
    .CH        (2),
    .DW        (16),
    .FRAME_LEN (8),
    .DIR_MASK  (2'b10),
    .SEED      (32'hACE1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear     (clear),
    .mode      (mode),
    .step      (step),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sync  (out_sync),
    .out_last  (out_last),
    .frame_cnt (frame_cnt),
    .inj_err   (inj_err)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  typedef struct packed {
    logic        en;
    logic        rdy;
    logic        v;
    logic [15:0] l0;
    logic [15:0] l1;
    logic        s;
    logic        la;
    logic [15:0] f;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        l;
    logic [15:0] f;
  } exp_t;

  vec_t tbl [12];
  exp_t sbq [$];

  logic [15:0] m_l0;
  logic [15:0] m_l1;
  int          m_idx;
  int          m_frame;
  logic [1:0]  m_mode;

  function automatic logic [15:0] lfsr16(input logic [15:0] x);
    logic fb;
    fb = x[15] ^ x[13] ^ x[12] ^ x[10];
    return {x[14:0], fb};
  endfunction

  task automatic m_init(input logic [1:0] md,
                        input logic [15:0] st);
    case (md)
      2'd0: begin m_l0 = 16'h0000; m_l1 = 16'h0000; end
      2'd1: begin m_l0 = 16'hACE0; m_l1 = 16'hACE3; end
      2'd2: begin m_l0 = st;       m_l1 = st;       end
      default: begin m_l0 = 16'h0001; m_l1 = 16'h0002; end
    endcase
  endtask

  task automatic m_adv();
    bit wrap;
    if (clear) begin
      m_idx   = 0;
      m_frame = 0;
      m_mode  = mode;
      m_init(mode, step);
    end else begin
      wrap  = (m_idx == 7);
      m_idx = wrap ? 0 : m_idx + 1;
      if (wrap) m_frame = (m_frame + 1) % 65536;
      if (wrap && mode != m_mode) begin
        m_mode = mode;
        m_init(mode, step);
      end else begin
        case (m_mode)
          2'd0: begin m_l0 = m_l0 - step; m_l1 = m_l1 + step; end
          2'd1: begin m_l0 = lfsr16(m_l0); m_l1 = lfsr16(m_l1); end
          2'd2: begin m_l0 = step; m_l1 = step; end
          default: begin
            m_l0 = {m_l0[14:0], m_l0[15]};
            m_l1 = {m_l1[14:0], m_l1[15]};
          end
        endcase
      end
    end
  endtask

  function automatic exp_t m_cur();
    exp_t e;
    e.d = {m_l1, m_l0};
    e.s = (m_idx == 0);
    e.l = (m_idx == 7);
    e.f = 16'(m_frame);
    return e;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   tcount;
    int   cyc;

    //            en   rdy  v    l0        l1        s    la   f
    tbl[0]  = '{1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'd0};
    tbl[1]  = '{1'b1,1'b1,1'b1,16'h0000,16'h0000,1'b1,1'b0,16'd0};
    tbl[2]  = '{1'b1,1'b0,1'b1,16'hFFFF,16'h0001,1'b0,1'b0,16'd0};
    tbl[3]  = '{1'b1,1'b0,1'b1,16'hFFFF,16'h0001,1'b0,1'b0,16'd0};
    tbl[4]  = '{1'b1,1'b1,1'b1,16'hFFFF,16'h0001,1'b0,1'b0,16'd0};
    tbl[5]  = '{1'b1,1'b1,1'b1,16'hFFFE,16'h0002,1'b0,1'b0,16'd0};
    tbl[6]  = '{1'b1,1'b1,1'b1,16'hFFFD,16'h0003,1'b0,1'b0,16'd0};
    tbl[7]  = '{1'b1,1'b1,1'b1,16'hFFFC,16'h0004,1'b0,1'b0,16'd0};
    tbl[8]  = '{1'b1,1'b1,1'b1,16'hFFFB,16'h0005,1'b0,1'b0,16'd0};
    tbl[9]  = '{1'b1,1'b1,1'b1,16'hFFFA,16'h0006,1'b0,1'b0,16'd0};
    tbl[10] = '{1'b1,1'b1,1'b1,16'hFFF9,16'h0007,1'b0,1'b1,16'd0};
    tbl[11] = '{1'b1,1'b0,1'b1,16'hFFF8,16'h0008,1'b1,1'b0,16'd1};

    rst_n     = 1'b0;
    en        = 1'b0;
    clear     = 1'b0;
    mode      = 2'd0;
    step      = 16'd1;
    out_ready = 1'b0;
    inj_err   = 1'b0;

    @(negedge clk);
    chk("reset_state",
        {out_valid, out_sync, out_last, frame_cnt, out_data},
        64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("vec%0d", i),
          {out_valid, out_data[15:0], out_data[31:16],
           out_sync, out_last, frame_cnt},
          {tbl[i].v, tbl[i].l0, tbl[i].l1,
           tbl[i].s, tbl[i].la, tbl[i].f});
      en        = tbl[i].en;
      out_ready = tbl[i].rdy;
      @(negedge clk);
    end

    m_l0    = 16'hFFF8;
    m_l1    = 16'h0008;
    m_idx   = 0;
    m_frame = 1;
    m_mode  = 2'd0;
    sbq.push_back(m_cur());

    tcount = 0;
    cyc    = 0;
    while (tcount < 50 && cyc < 400) begin
      clear     = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      if (tcount == 3) mode = 2'd1;
      if (tcount == 13) begin
        clear     = 1'b1;
        out_ready = 1'b1;
        mode      = 2'd3;
      end
      if (tcount == 20) begin mode = 2'd2; step = 16'd5; end
      if (tcount == 30) begin mode = 2'd0; step = 16'd3; end
      if (out_valid && out_ready) begin
        e = sbq.pop_front();
        chk($sformatf("sb%0d", tcount),
            {out_data, out_sync, out_last, frame_cnt}, e);
        if (tcount == 8)
          chk("lfsr_first", {out_sync, out_data[15:0]},
              {1'b1, 16'hACE0});
        if (tcount == 9)
          chk("lfsr_second", out_data[15:0], 16'h59C1);
        if (tcount == 14)
          chk("clear_restart", {out_sync, frame_cnt, out_data},
              {1'b1, 16'h0000, 32'h0002_0001});
        m_adv();
        sbq.push_back(m_cur());
        tcount++;
      end
      @(negedge clk);
      cyc++;
    end
    if (tcount < 50) chk("sb_timeout", tcount, 50);

    clear     = 1'b0;
    mode      = 2'd0;
    step      = 16'd1;
    en        = 1'b1;
    out_ready = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    chk("async_rst",
        {out_valid, out_sync, out_last, frame_cnt, out_data},
        64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("restart", {out_valid, out_sync, frame_cnt, out_data},
        {1'b1, 1'b1, 16'h0000, 32'h0000_0000});
    inj_err   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    inj_err = 1'b0;
    chk("inj_sample", out_data, {16'h0001, 16'hFFFF ^ INJ});
    @(negedge clk);
    chk("post_inj", out_data, 32'h0002_FFFE);
    en        = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("en_low_hold", {out_valid, out_data},
        {1'b1, 32'h0002_FFFE});
    out_ready = 1'b1;
    @(negedge clk);
    chk("en_low_drop", {out_valid, out_data},
        {1'b0, 32'h0003_FFFD});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
